bcd_seq_ctrl: RTL and testbench

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

---
 rtl/bcd_seq_ctrl.sv | 99 +++++++++
 tb/tb_bcd_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// bcd_seq_ctrl: 10-bit binary to 4-digit BCD via shift-add-3; optional BLANK port under BCD_BLANK_EN.
// Latency: START sampled in IDLE at edge N -> DONE pulse and new digits after edge N+11.
// Backpressure: none; START is ignored (not queued) while BUSY=1.
module bcd_seq_ctrl (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       START,
  input  logic [9:0] BIN,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3
`ifdef BCD_BLANK_EN
  ,
  output logic [3:0] BLANK
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  opnd;
  logic [15:0] scr;
  logic [15:0] adj;
  logic [3:0]  cnt;

  always_ff @(posedge CLOCK_50) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_SHIFT;
      S_SHIFT: if (cnt == 4'd9) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // add-3 correction applied to every nibble before the shift
  always_comb begin
    adj = scr;
    for (int i = 0; i < 4; i++) begin
      if (scr[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr[4*i +: 4] + 4'd3;
    end
  end

  assign BUSY = (state != S_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      opnd <= '0;
      scr  <= '0;
      cnt  <= '0;
      DONE <= 1'b0;
      BCD0 <= '0;
      BCD1 <= '0;
      BCD2 <= '0;
      BCD3 <= '0;
`ifdef BCD_BLANK_EN
      BLANK <= 4'b1110;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            opnd <= BIN;
            scr  <= '0;
            cnt  <= '0;
          end
        end
        S_SHIFT: begin
          {scr, opnd} <= {adj, opnd} << 1;
          cnt         <= cnt + 4'd1;
        end
        S_DONE: begin
          DONE <= 1'b1;
          BCD0 <= scr[3:0];
          BCD1 <= scr[7:4];
          BCD2 <= scr[11:8];
          BCD3 <= scr[15:12];
`ifdef BCD_BLANK_EN
          BLANK[3] <= (scr[15:12] == 4'd0);
          BLANK[2] <= (scr[15:8]  == 8'd0);
          BLANK[1] <= (scr[15:4]  == 12'd0);
          BLANK[0] <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Scoreboard bench for bcd_seq_ctrl: stimulus pushes hand-computed results and
// the DONE cycle they must appear on; a negedge monitor pops and compares.
module tb_bcd_seq_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [9:0] BIN = '0;
  logic       BUSY, DONE;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
`ifdef BCD_BLANK_EN
  logic [3:0] BLANK;
`endif

  bcd_seq_ctrl dut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .START    (START),
    .BIN      (BIN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .BCD0     (BCD0),
    .BCD1     (BCD1),
    .BCD2     (BCD2),
    .BCD3     (BCD3)
`ifdef BCD_BLANK_EN
    ,
    .BLANK    (BLANK)
`endif
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  blank;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (DONE === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {31'd0, DONE}, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("done_cycle", cyc, mon_e.at);
        chk("digits", {16'd0, BCD3, BCD2, BCD1, BCD0}, {16'd0, mon_e.bcd});
        chk("busy_after_done", {31'd0, BUSY}, 32'd0);
`ifdef BCD_BLANK_EN
        chk("blank", {28'd0, BLANK}, {28'd0, mon_e.blank});
`endif
      end
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // launch edge is the next posedge; result must be visible at the negedge 11 edges later
  task automatic launch(input logic [9:0] b, input logic [15:0] e, input logic [3:0] bl,
                        input bit expect_done);
    exp_t x;
    BIN   = b;
    START = 1'b1;
    if (expect_done) begin
      x.bcd = e; x.blank = bl; x.at = cyc + 12;
      q.push_back(x);
    end
    step();
    START = 1'b0;
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
  endtask

  task automatic drain(input logic [15:0] e);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) step();
    chk("hold_digits", {16'd0, BCD3, BCD2, BCD1, BCD0}, {16'd0, e});
    chk("busy_idle", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    // reset wins over a simultaneous START
    RST = 1'b1; START = 1'b1; BIN = 10'd5;
    step(); step();
    START = 1'b0; RST = 1'b0;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_digits", {16'd0, BCD3, BCD2, BCD1, BCD0}, 32'd0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", {28'd0, BLANK}, 32'h0000_000e);
`endif
    step();

    launch(10'd0,    16'h0000, 4'b1110, 1'b1); drain(16'h0000);
    launch(10'd1023, 16'h1023, 4'b0000, 1'b1); drain(16'h1023);
    launch(10'd999,  16'h0999, 4'b1000, 1'b1); drain(16'h0999);
    launch(10'd512,  16'h0512, 4'b1000, 1'b1); drain(16'h0512);

    // second START at conversion cycle 3 with a different operand is dropped
    launch(10'd321, 16'h0321, 4'b1000, 1'b1);
    step();
    BIN = 10'd654; START = 1'b1;
    step();
    START = 1'b0;
    drain(16'h0321);

    // reset on the 5th SHIFT edge aborts with no DONE
    launch(10'd777, 16'h0000, 4'b0000, 1'b0);
    repeat (4) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("abort_busy", {31'd0, BUSY}, 32'd0);
    chk("abort_digits", {16'd0, BCD3, BCD2, BCD1, BCD0}, 32'd0);
    repeat (15) step();
    launch(10'd88, 16'h0088, 4'b1100, 1'b1); drain(16'h0088);

    // START held high: three launches 12 cycles apart, BIN changed mid-conversion
    START = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t x;
      BIN = 10'd5 + 10'(k);
      x.bcd = 16'h0005 + 16'(k); x.blank = 4'b1110; x.at = cyc + 12;
      q.push_back(x);
      step();
      BIN = 10'd1000;
      repeat (11) step();
    end
    START = 1'b0;
    drain(16'h0007);

    launch(10'd7,    16'h0007, 4'b1110, 1'b1); drain(16'h0007);
    launch(10'd40,   16'h0040, 4'b1100, 1'b1); drain(16'h0040);
    launch(10'd1000, 16'h1000, 4'b0000, 1'b1); drain(16'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
